// File: rtl/drive_pkg.sv
// Shared encodings, wheel FSM state type and steering-code decode for drive_sequencer.
package drive_pkg;

    localparam logic [1:0] DIR_STRAIGHT  = 2'b00;
    localparam logic [1:0] DIR_LEFT      = 2'b01;
    localparam logic [1:0] DIR_RIGHT     = 2'b10;
    localparam logic [1:0] DIR_STOP      = 2'b11;

    localparam logic [1:0] MODE_FULL     = 2'b00;
    localparam logic [1:0] MODE_VEER     = 2'b01;
    localparam logic [1:0] MODE_VEER_ALT = 2'b10;
    localparam logic [1:0] MODE_90       = 2'b11;

    typedef enum logic [1:0] {
        ST_RUN,
        ST_DECEL,
        ST_COAST,
        ST_FLIP
    } wheel_state_t;

    typedef struct packed {
        logic [7:0] l_duty;
        logic       l_fwd;
        logic [7:0] r_duty;
        logic       r_fwd;
    } drive_target_t;

    // A turn with MODE_FULL has no inner wheel, so it drives like straight.
    function automatic drive_target_t decode_target(
        input logic [3:0] dir,
        input logic       enable,
        input logic       cur_l_fwd,
        input logic       cur_r_fwd,
        input logic [7:0] full,
        input logic [7:0] veer,
        input logic [7:0] pivot
    );
        drive_target_t t;
        t.l_duty = full;
        t.l_fwd  = 1'b1;
        t.r_duty = full;
        t.r_fwd  = 1'b1;
        case (dir[1:0])
            MODE_VEER, MODE_VEER_ALT: begin
                if (dir[3:2] == DIR_LEFT)  t.l_duty = veer;
                if (dir[3:2] == DIR_RIGHT) t.r_duty = veer;
            end
            MODE_90: begin
                if (dir[3:2] == DIR_LEFT || dir[3:2] == DIR_RIGHT) begin
                    t.l_duty = pivot;
                    t.r_duty = pivot;
                    t.l_fwd  = (dir[3:2] != DIR_LEFT);
                    t.r_fwd  = (dir[3:2] != DIR_RIGHT);
                end
            end
            default: ;
        endcase
        if (!enable || dir[3:2] == DIR_STOP ||
            (dir[3:2] == DIR_STRAIGHT && dir[1:0] == MODE_90)) begin
            t.l_duty = '0;
            t.r_duty = '0;
            t.l_fwd  = cur_l_fwd;
            t.r_fwd  = cur_r_fwd;
        end
        return t;
    endfunction

endpackage

// File: rtl/wheel_ramp.sv
// One wheel: duty ramp toward target, decel/coast/flip sequence for reversal, e-stop.
module wheel_ramp
    import drive_pkg::*;
#(
    parameter int unsigned RAMP_STEP = 8,
    parameter int unsigned DEADTIME  = 500_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_estop,
    input  logic       i_tick,
    input  logic [7:0] i_tgt_duty,
    input  logic       i_tgt_fwd,
    output logic [7:0] o_duty,
    output logic       o_fwd,
    output logic       o_busy
);

    localparam int unsigned CW    = (DEADTIME > 1) ? $clog2(DEADTIME + 1) : 1;
    localparam logic [8:0]  STEP9 = 9'(RAMP_STEP);

    wheel_state_t  r_state, w_state_nxt;
    logic [7:0]    r_duty, w_duty_nxt;
    logic          r_fwd, w_fwd_nxt;
    logic [CW-1:0] r_coast, w_coast_nxt;
    logic [7:0]    w_diff_up, w_diff_dn, w_inc, w_dec, w_dec0;

    // Step sizes clamp to the remaining distance so duty lands exactly on target.
    assign w_diff_up = i_tgt_duty - r_duty;
    assign w_diff_dn = r_duty - i_tgt_duty;
    assign w_inc     = ({1'b0, w_diff_up} > STEP9) ? STEP9[7:0] : w_diff_up;
    assign w_dec     = ({1'b0, w_diff_dn} > STEP9) ? STEP9[7:0] : w_diff_dn;
    assign w_dec0    = ({1'b0, r_duty}    > STEP9) ? STEP9[7:0] : r_duty;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_RUN;
            r_duty  <= '0;
            r_fwd   <= 1'b1;
            r_coast <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_duty  <= w_duty_nxt;
            r_fwd   <= w_fwd_nxt;
            r_coast <= w_coast_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_duty_nxt  = r_duty;
        w_fwd_nxt   = r_fwd;
        w_coast_nxt = r_coast;
        if (i_estop) begin
            w_state_nxt = ST_RUN;
            w_duty_nxt  = '0;
            w_coast_nxt = '0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    if (i_tgt_fwd != r_fwd) begin
                        w_state_nxt = ST_DECEL;
                    end else if (i_tick) begin
                        if (i_tgt_duty > r_duty)      w_duty_nxt = r_duty + w_inc;
                        else if (i_tgt_duty < r_duty) w_duty_nxt = r_duty - w_dec;
                    end
                end
                ST_DECEL: begin
                    if (i_tgt_fwd == r_fwd) begin
                        w_state_nxt = ST_RUN;
                    end else if (r_duty == '0) begin
                        w_state_nxt = ST_COAST;
                        w_coast_nxt = CW'(DEADTIME);
                    end else if (i_tick) begin
                        w_duty_nxt = r_duty - w_dec0;
                    end
                end
                ST_COAST: begin
                    if (i_tgt_fwd == r_fwd) begin
                        w_state_nxt = ST_RUN;
                        w_coast_nxt = '0;
                    end else if (r_coast <= CW'(1)) begin
                        w_state_nxt = ST_FLIP;
                        w_coast_nxt = '0;
                    end else begin
                        w_coast_nxt = r_coast - CW'(1);
                    end
                end
                ST_FLIP: begin
                    w_fwd_nxt   = ~r_fwd;
                    w_state_nxt = ST_RUN;
                end
                default: w_state_nxt = ST_RUN;
            endcase
        end
    end

    assign o_duty = r_duty;
    assign o_fwd  = r_fwd;
    assign o_busy = (r_state != ST_RUN) || (r_duty != i_tgt_duty) || (r_fwd != i_tgt_fwd);

endmodule

// File: rtl/drive_sequencer.sv
// Steering code to left/right PWM + direction, with shared ramp tick and PWM counter.
module drive_sequencer
    import drive_pkg::*;
#(
    parameter int unsigned FULL_DUTY    = 240,
    parameter int unsigned VEER_DUTY    = 128,
    parameter int unsigned PIVOT_DUTY   = 160,
    parameter int unsigned RAMP_TICKS   = 50_000,
    parameter int unsigned RAMP_STEP    = 8,
    parameter int unsigned DEADTIME     = 500_000,
    parameter int unsigned PWM_PRESCALE = 8
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] dir,
    input  logic       enable,
    input  logic       estop,
    output logic       l_pwm,
    output logic       r_pwm,
    output logic       l_fwd,
    output logic       r_fwd,
    output logic       busy
);

    localparam int unsigned TW = (RAMP_TICKS > 1)   ? $clog2(RAMP_TICKS)   : 1;
    localparam int unsigned PW = (PWM_PRESCALE > 1) ? $clog2(PWM_PRESCALE) : 1;

    logic [3:0]    r_dir;
    logic [TW-1:0] r_tick_cnt;
    logic [PW-1:0] r_pre;
    logic [7:0]    r_pwm_cnt;
    logic          r_l_pwm, r_r_pwm;
    logic          w_tick;
    drive_target_t w_tgt;
    logic [7:0]    w_l_duty, w_r_duty;
    logic          w_l_fwd, w_r_fwd, w_l_busy, w_r_busy;

    assign w_tick = (r_tick_cnt == TW'(RAMP_TICKS - 1));
    assign w_tgt  = decode_target(r_dir, enable, w_l_fwd, w_r_fwd,
                                  8'(FULL_DUTY), 8'(VEER_DUTY), 8'(PIVOT_DUTY));

    // Registered dir resets to a stop code so targets are zero straight out of reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_dir      <= {DIR_STOP, MODE_FULL};
            r_tick_cnt <= '0;
            r_pre      <= '0;
            r_pwm_cnt  <= '0;
            r_l_pwm    <= 1'b0;
            r_r_pwm    <= 1'b0;
        end else begin
            r_dir      <= dir;
            r_tick_cnt <= w_tick ? '0 : r_tick_cnt + TW'(1);
            if (r_pre == PW'(PWM_PRESCALE - 1)) begin
                r_pre     <= '0;
                r_pwm_cnt <= r_pwm_cnt + 8'd1;
            end else begin
                r_pre <= r_pre + PW'(1);
            end
            r_l_pwm <= !estop && (r_pwm_cnt < w_l_duty);
            r_r_pwm <= !estop && (r_pwm_cnt < w_r_duty);
        end
    end

    wheel_ramp #(.RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)) u_left (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_estop    (estop),
        .i_tick     (w_tick),
        .i_tgt_duty (w_tgt.l_duty),
        .i_tgt_fwd  (w_tgt.l_fwd),
        .o_duty     (w_l_duty),
        .o_fwd      (w_l_fwd),
        .o_busy     (w_l_busy)
    );

    wheel_ramp #(.RAMP_STEP(RAMP_STEP), .DEADTIME(DEADTIME)) u_right (
        .clk        (clk),
        .rst_n      (rst_n),
        .i_estop    (estop),
        .i_tick     (w_tick),
        .i_tgt_duty (w_tgt.r_duty),
        .i_tgt_fwd  (w_tgt.r_fwd),
        .o_duty     (w_r_duty),
        .o_fwd      (w_r_fwd),
        .o_busy     (w_r_busy)
    );

    assign l_pwm = r_l_pwm;
    assign r_pwm = r_r_pwm;
    assign l_fwd = w_l_fwd;
    assign r_fwd = w_r_fwd;
    assign busy  = w_l_busy || w_r_busy;

endmodule

// File: tb/tb_drive_sequencer.sv
// Scoreboard bench for drive_sequencer: a behavioural model queues expected outputs per clock.
module tb_drive_sequencer;

    localparam int FULL = 240, VEER = 128, PIVOT = 160;
    localparam int RT = 4, RS = 16, DT = 8, PRE = 1;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] dir = 4'b1100;
    logic       enable = 1'b0;
    logic       estop = 1'b0;
    logic       l_pwm, r_pwm, l_fwd, r_fwd, busy;

    always #5 clk = ~clk;

    drive_sequencer #(
        .FULL_DUTY(FULL), .VEER_DUTY(VEER), .PIVOT_DUTY(PIVOT),
        .RAMP_TICKS(RT), .RAMP_STEP(RS), .DEADTIME(DT), .PWM_PRESCALE(PRE)
    ) dut (
        .clk(clk), .rst_n(rst_n), .dir(dir), .enable(enable), .estop(estop),
        .l_pwm(l_pwm), .r_pwm(r_pwm), .l_fwd(l_fwd), .r_fwd(r_fwd), .busy(busy)
    );

    int n_vec = 0;
    int n_bad = 0;
    int cyc = 0;

    typedef struct {
        logic [4:0] exp;
        int         cyc;
    } exp_t;
    exp_t sb[$];

    // Model: wheel phases as plain ints (0 driving, 1 slowing for reversal, 2 coasting, 3 flipping).
    int m_rdir, m_tick, m_pre, m_pcnt;
    int m_duty[2], m_fwd[2], m_ph[2], m_coast[2];
    bit m_pwm[2];

    function automatic void target(input int d, input bit en, input int w, input int cur,
                                   output int td, output int tf);
        int turn, mode, inner;
        turn = (d >> 2) & 3;
        mode = d & 3;
        td = FULL;
        tf = 1;
        if (!en || turn == 3 || (turn == 0 && mode == 3)) begin
            td = 0;
            tf = cur;
            return;
        end
        if (turn == 0 || mode == 0) return;
        inner = (turn == 1) ? 0 : 1;
        if (mode == 3) begin
            td = PIVOT;
            tf = (w == inner) ? 0 : 1;
        end else if (w == inner) begin
            td = VEER;
        end
    endfunction

    task automatic model_step(input bit rst, input bit est, input bit en, input int d);
        int td[2], tf[2];
        int delta;
        bit tick;
        if (!rst) begin
            m_rdir = 12; m_tick = 0; m_pre = 0; m_pcnt = 0;
            for (int w = 0; w < 2; w++) begin
                m_duty[w] = 0; m_fwd[w] = 1; m_ph[w] = 0; m_coast[w] = 0; m_pwm[w] = 0;
            end
            return;
        end
        tick = (m_tick == RT - 1);
        for (int w = 0; w < 2; w++) begin
            target(m_rdir, en, w, m_fwd[w], td[w], tf[w]);
            m_pwm[w] = !est && (m_pcnt < m_duty[w]);
        end
        m_rdir = d;
        m_tick = tick ? 0 : m_tick + 1;
        if (m_pre == PRE - 1) begin
            m_pre = 0;
            m_pcnt = (m_pcnt + 1) % 256;
        end else begin
            m_pre++;
        end
        for (int w = 0; w < 2; w++) begin
            if (est) begin
                m_duty[w] = 0; m_ph[w] = 0; m_coast[w] = 0;
            end else if (m_ph[w] == 0) begin
                if (tf[w] != m_fwd[w]) m_ph[w] = 1;
                else if (tick) begin
                    delta = td[w] - m_duty[w];
                    if (delta > RS) delta = RS;
                    if (delta < -RS) delta = -RS;
                    m_duty[w] += delta;
                end
            end else if (m_ph[w] == 1) begin
                if (tf[w] == m_fwd[w]) m_ph[w] = 0;
                else if (m_duty[w] == 0) begin m_ph[w] = 2; m_coast[w] = DT; end
                else if (tick) m_duty[w] -= (m_duty[w] < RS) ? m_duty[w] : RS;
            end else if (m_ph[w] == 2) begin
                if (tf[w] == m_fwd[w]) begin m_ph[w] = 0; m_coast[w] = 0; end
                else if (m_coast[w] <= 1) begin m_ph[w] = 3; m_coast[w] = 0; end
                else m_coast[w]--;
            end else begin
                m_fwd[w] = 1 - m_fwd[w];
                m_ph[w] = 0;
            end
        end
    endtask

    function automatic logic [4:0] exp_vec(input bit en);
        int td, tf;
        bit b;
        b = 0;
        for (int w = 0; w < 2; w++) begin
            target(m_rdir, en, w, m_fwd[w], td, tf);
            if (m_ph[w] != 0 || m_duty[w] != td || m_fwd[w] != tf) b = 1;
        end
        return {m_pwm[0], m_pwm[1], m_fwd[0][0], m_fwd[1][0], b};
    endfunction

    task automatic cycle(input logic [3:0] d, input logic en, input logic es, input logic rs);
        exp_t e;
        @(posedge clk);
        model_step(rst_n, estop, enable, int'(dir));
        #1;
        dir = d; enable = en; estop = es; rst_n = rs;
        e.exp = exp_vec(enable);
        e.cyc = cyc;
        sb.push_back(e);
        cyc++;
    endtask

    task automatic run(input logic [3:0] d, input logic en, input logic es, input int n);
        for (int i = 0; i < n; i++) cycle(d, en, es, 1'b1);
    endtask

    initial begin : monitor
        exp_t e;
        logic [4:0] act;
        forever begin
            @(negedge clk);
            if (sb.size() > 0) begin
                e = sb.pop_front();
                act = {l_pwm, r_pwm, l_fwd, r_fwd, busy};
                n_vec++;
                if (act !== e.exp) begin
                    n_bad++;
                    $display("FAIL outputs{lpwm,rpwm,lfwd,rfwd,busy} cycle %0d: got %b expected %b",
                             e.cyc, act, e.exp);
                end
            end
        end
    end

    initial begin : stim
        int hi;
        int len;
        cycle(4'b1100, 1'b0, 1'b0, 1'b0);
        cycle(4'b1100, 1'b0, 1'b0, 1'b0);
        cycle(4'b0000, 1'b1, 1'b0, 1'b1);
        run(4'b0000, 1'b1, 1'b0, 80);
        hi = 0;
        for (int i = 0; i < 256; i++) begin
            cycle(4'b0000, 1'b1, 1'b0, 1'b1);
            @(negedge clk);
            hi += int'(l_pwm);
        end
        n_vec++;
        if (hi != 240) begin
            n_bad++;
            $display("FAIL l_pwm_high_per_period: got %0d expected %0d", hi, 240);
        end
        run(4'b0101, 1'b1, 1'b0, 60);
        run(4'b0000, 1'b1, 1'b0, 40);
        run(4'b0111, 1'b1, 1'b0, 120);
        run(4'b0000, 1'b1, 1'b0, 120);
        run(4'b0111, 1'b1, 1'b0, 65);
        run(4'b0000, 1'b1, 1'b0, 80);
        run(4'b0000, 1'b1, 1'b1, 10);
        run(4'b0000, 1'b1, 1'b0, 80);
        run(4'b1111, 1'b1, 1'b0, 30);
        cycle(4'b1111, 1'b1, 1'b0, 1'b0);
        run(4'b0000, 1'b1, 1'b0, 40);
        run(4'b1011, 1'b1, 1'b0, 120);
        for (int s = 0; s < 60; s++) begin
            len = $urandom_range(1, 90);
            if ($urandom % 25 == 0) cycle(4'($urandom), 1'b1, 1'b0, 1'b0);
            run(4'($urandom), ($urandom % 8) != 0, ($urandom % 16) == 0, len);
        end
        @(negedge clk);
        #1;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
